// File: rtl/regfile.sv
// regfile: 32 x DWIDTH general-purpose register file for the semiMIPS datapath.
// Two combinational read ports, one synchronous write port, register 0 reads
// as zero. Asynchronous active-low reset clears the array and forces reads to 0.
// Optional build macro REGFILE_BYPASS_EN: write-through forwarding from din to
// each read port when it addresses the register being written this cycle.
module regfile #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        rdaddr1,
  input  logic [4:0]        rdaddr2,
  input  logic [4:0]        wraddr,
  input  logic              wr,
  input  logic [DWIDTH-1:0] din,
  output logic [DWIDTH-1:0] dout1,
  output logic [DWIDTH-1:0] dout2
);

  localparam int unsigned NREGS = 32;

  // Entry 0 exists so every 5-bit index is in range; it is never written and
  // stays at its reset value of zero.
  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];
  logic              wr_en;

  assign wr_en = wr && (wraddr != 5'd0);

  // Next-state of the array: only the addressed nonzero entry takes din.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_en) begin
      regs_d[wraddr] = din;
    end
  end

  // Storage update; reset clears every entry without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read port 1: reset and register 0 override everything, then forwarding.
  always_comb begin
    dout1 = '0;
    if (rst_n && (rdaddr1 != 5'd0)) begin
      dout1 = regs_q[rdaddr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wraddr == rdaddr1)) begin
        dout1 = din;
      end
`endif
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    dout2 = '0;
    if (rst_n && (rdaddr2 != 5'd0)) begin
      dout2 = regs_q[rdaddr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wraddr == rdaddr2)) begin
        dout2 = din;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed plus randomized checks of regfile against an array model.
module tb_regfile;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic [4:0]   rdaddr1;
  logic [4:0]   rdaddr2;
  logic [4:0]   wraddr;
  logic         wr;
  logic [W-1:0] din;
  logic [W-1:0] dout1;
  logic [W-1:0] dout2;

  int unsigned  n_checks = 0;
  int unsigned  n_fail   = 0;

  logic [W-1:0] model [32];

  regfile #(.DWIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdaddr1 (rdaddr1),
    .rdaddr2 (rdaddr2),
    .wraddr  (wraddr),
    .wr      (wr),
    .din     (din),
    .dout1   (dout1),
    .dout2   (dout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value for address a given the current inputs.
  function automatic logic [W-1:0] exp_rd(input logic [4:0] a);
    if (!rst_n || a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr && wraddr != 5'd0 && wraddr == a) return din;
`endif
    return model[a];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // One write of d to register a, driven between edges, wr dropped afterwards.
  task automatic do_write(input logic [4:0] a, input logic [W-1:0] d);
    @(negedge clk);
    wr = 1'b1; wraddr = a; din = d;
    @(posedge clk);
    if (a != 5'd0) model[a] = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rdaddr1 = a1; rdaddr2 = a2;
    #1;
    chk({tag, "_p1"}, dout1, exp_rd(a1));
    chk({tag, "_p2"}, dout2, exp_rd(a2));
  endtask

  initial begin
    logic [W-1:0] v;
    rst_n = 1'b0; wr = 1'b0; wraddr = '0; din = '0; rdaddr1 = 5'd5; rdaddr2 = 5'd31;
    clear_model();

    // Reset state.
    #12;
    chk("reset_p1", dout1, 32'h0);
    chk("reset_p2", dout2, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("after_reset", 5'd5, 5'd31);

    // Basic write/read.
    do_write(5'd5,  32'h192489AC);
    do_write(5'd14, 32'h70CA7800);
    rdaddr1 = 5'd14; rdaddr2 = 5'd5;
    #1;
    chk("basic_rd14", dout1, 32'h70CA7800);
    chk("basic_rd5",  dout2, 32'h192489AC);

    // Write disable across three edges.
    @(negedge clk);
    wr = 1'b0; wraddr = 5'd14; din = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("wr_disable", dout1, 32'h70CA7800);

    // Simultaneous read/write of register 5 on port 2.
    @(negedge clk);
    rdaddr2 = 5'd5; wraddr = 5'd5; din = 32'h658921D3; wr = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("rw_same_pre", dout2, 32'h658921D3);
`else
    chk("rw_same_pre", dout2, 32'h192489AC);
`endif
    @(posedge clk);
    model[5] = 32'h658921D3;
    #1;
    chk("rw_same_post", dout2, 32'h658921D3);
    @(negedge clk);
    wr = 1'b0;

    // Register zero ignores writes.
    do_write(5'd0, 32'hDEADBEEF);
    rdaddr1 = 5'd0;
    #1;
    chk("reg0_read", dout1, 32'h0);

    // Both ports on the same register.
    rdaddr1 = 5'd14; rdaddr2 = 5'd14;
    #1;
    chk("dual_p1", dout1, 32'h70CA7800);
    chk("dual_p2", dout2, 32'h70CA7800);

    // Sweep all nonzero registers with unique data.
    for (int a = 1; a < 32; a++) begin
      v = 32'h01010101 * a;
      do_write(5'(a), v);
    end
    for (int a = 1; a < 32; a++) begin
      rd_check("sweep", 5'(a), 5'(a));
      chk("sweep_const", dout1, 32'h01010101 * a);
    end

    // Held write enable rewrites the same value each edge.
    @(negedge clk);
    wr = 1'b1; wraddr = 5'd9; din = 32'hA5A5F00D; rdaddr1 = 5'd9; rdaddr2 = 5'd10;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      model[9] = 32'hA5A5F00D;
      #1;
      chk("held_wr_p1", dout1, 32'hA5A5F00D);
      chk("held_wr_p2", dout2, exp_rd(5'd10));
    end
    @(negedge clk);
    wr = 1'b0;

    // Randomized traffic against the model, checked before and after each edge.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      wr      = 1'($urandom_range(0, 1));
      wraddr  = (i % 7 == 0) ? 5'd0 : 5'($urandom);
      din     = $urandom;
      rdaddr1 = 5'($urandom);
      rdaddr2 = (i % 4 == 0) ? wraddr : 5'($urandom);
      #1;
      chk("rand_pre_p1", dout1, exp_rd(rdaddr1));
      chk("rand_pre_p2", dout2, exp_rd(rdaddr2));
      @(posedge clk);
      if (wr && wraddr != 5'd0) model[wraddr] = din;
      #1;
      chk("rand_post_p1", dout1, exp_rd(rdaddr1));
      chk("rand_post_p2", dout2, exp_rd(rdaddr2));
    end
    @(negedge clk);
    wr = 1'b0;

    // Mid-simulation reset clears immediately and blocks writes.
    do_write(5'd5, 32'h192489AC);
    rdaddr1 = 5'd5; rdaddr2 = 5'd7;
    #1;
    chk("pre_rst_rd5", dout1, 32'h192489AC);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_p1", dout1, 32'h0);
    chk("async_rst_p2", dout2, 32'h0);
    clear_model();
    wr = 1'b1; wraddr = 5'd7; din = 32'hAAAA5555;
    @(posedge clk);
    #1;
    chk("rst_wr_ignored", dout2, 32'h0);
    @(negedge clk);
    wr = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_rd5", dout1, 32'h0);
    chk("post_rst_rd7", dout2, 32'h0);
    rd_check("post_rst_model", 5'd14, 5'd31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
